// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_pkg
//  Description : Shared types for the USB receive path. These are the PID class
//                codes produced by usb_rx and the state encoding of the
//                receive packet buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // PID class codes shared with usb_rx
    typedef enum logic [2:0] {
        RX_NONE      = 3'd0,
        RX_TOKEN_OUT = 3'd1,
        RX_TOKEN_IN  = 3'd2,
        RX_DATA0     = 3'd3,
        RX_DATA1     = 3'd4,
        RX_ACK       = 3'd5,
        RX_NAK       = 3'd6,
        RX_SETUP     = 3'd7
    } rx_pkt_t;

    // Receive buffer packet-tracking states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        COMMIT  = 2'd2,
        DISCARD = 2'd3
    } rxbuf_state_t;

endpackage
`default_nettype wire

// File: rtl/rxbuf_mem.sv
`default_nettype none
// ============================================================================
//  Module      : rxbuf_mem
//  Description : DEPTH x 8 register file with one synchronous write port and
//                one registered read port. The read register holds its value
//                when no read is requested.
//  Revision    : 1.0 - initial release
// ============================================================================
module rxbuf_mem #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Storage array: written on every accepted byte, never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register: loads only on a read, otherwise holds the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 8'h00;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/usb_rx_packet_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_rx_packet_buffer
//  Description : Circular byte store behind usb_rx. Payload bytes are written
//                speculatively and become visible to the reader only when the
//                packet ends without error. Errored or overflowed packets are
//                rolled back. The PID class of each good packet is latched.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_packet_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              store_rx_packet,
    input  logic [7:0]        rx_packet_data,
    input  logic [2:0]        rx_packet,
    input  logic              packet_done,
    input  logic              r_error,
    input  logic              get_rx_data,
    input  logic              flush,
    output logic [7:0]        rx_data,
    output logic              rx_data_valid,
    output logic [ADDR_W:0]   occupancy,
    output logic              pkt_valid,
    output logic [2:0]        pkt_type,
    output logic              overflow
);

    localparam logic [ADDR_W:0] c_FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_cm_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    rxbuf_state_t    r_state;
    rx_pkt_t         r_pkt_latched;
    rx_pkt_t         r_pkt_type;
    logic            r_pkt_bad;
    logic            r_overflow;
    logic            r_pkt_valid;
    logic            r_rx_data_valid;

    logic [ADDR_W:0] w_occupancy;
    logic            w_full;
    logic            w_pop;
    logic            w_write;
    logic            w_drop;

    // Full counts every byte not yet read, committed or speculative
    assign w_occupancy = r_cm_ptr - r_rd_ptr;
    assign w_full      = (r_wr_ptr - r_rd_ptr) == c_FULL_COUNT;
    assign w_pop       = get_rx_data && (w_occupancy != '0) && !flush;
    assign w_write     = store_rx_packet && !w_full && !flush;
    assign w_drop      = store_rx_packet && w_full;

    rxbuf_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (rx_packet_data),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (rx_data)
    );

    // Pointer bookkeeping and packet commit/rollback state machine
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr        <= '0;
            r_cm_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_state         <= IDLE;
            r_pkt_latched   <= RX_NONE;
            r_pkt_type      <= RX_NONE;
            r_pkt_bad       <= 1'b0;
            r_overflow      <= 1'b0;
            r_pkt_valid     <= 1'b0;
            r_rx_data_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr        <= '0;
            r_cm_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_state         <= IDLE;
            r_pkt_bad       <= 1'b0;
            r_overflow      <= 1'b0;
            r_pkt_valid     <= 1'b0;
            r_rx_data_valid <= 1'b0;
        end else begin
            r_pkt_valid     <= 1'b0;
            r_rx_data_valid <= w_pop;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_pkt_bad  <= 1'b1;
            end
            case (r_state)
                IDLE, RECV: begin
                    // A packet_done in IDLE is a payload-less packet and is judged the same way
                    if (packet_done) begin
                        r_pkt_latched <= rx_pkt_t'(rx_packet);
                        r_state       <= (!r_error && !r_pkt_bad && !w_drop) ? COMMIT : DISCARD;
                    end else if (r_state == IDLE && store_rx_packet) begin
                        r_state <= RECV;
                    end
                end
                COMMIT: begin
                    r_cm_ptr    <= r_wr_ptr;
                    r_pkt_type  <= r_pkt_latched;
                    r_pkt_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                DISCARD: begin
                    r_wr_ptr  <= r_cm_ptr;
                    r_pkt_bad <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data_valid = r_rx_data_valid;
    assign occupancy     = w_occupancy;
    assign pkt_valid     = r_pkt_valid;
    assign pkt_type      = r_pkt_type;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
